// File: rtl/garage_door_pkg.sv
`default_nettype none
// ============================================================================
// Module : garage_door_pkg
// Brief  : Shared encodings and counter-width helper for the door monitor.
// Rev    : 1.0
// ============================================================================
package garage_door_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        Mv_Up = 2'b01,
        Mv_Dn = 2'b10
    } ctrl_state_e;

    typedef enum logic [1:0] {
        MON_IDLE  = 2'b00,
        MON_RUN   = 2'b01,
        MON_FAULT = 2'b10
    } mon_state_e;

    // Bits needed for a counter that must hold values 0 .. n-1.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/garage_door_position_monitor_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module : sync_debounce
// Brief  : 2-flop synchronizer with optional stable-level debounce counter.
// Rev    : 1.0
// ============================================================================
module sync_debounce
    import garage_door_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter bit BYPASS     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
        end
    end

    generate
        if (BYPASS) begin : g_bypass
            assign level_o = sync_q;
        end else begin : g_deb
            localparam int CNT_W = cnt_width(DEB_CYCLES);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;
            logic             stable_q;

            // A new level is accepted only after DEB_CYCLES consecutive mismatches.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else if (sync_q != stable_q) begin
                    if (cnt_q == CNT_LAST) begin
                        stable_q <= sync_q;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_q <= '0;
                end
            end

            assign level_o = stable_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/garage_door_position_monitor.sv
`default_nettype none
// ============================================================================
// Module : garage_door_position_monitor
// Brief  : Tracks door position from encoder ticks, debounces the remote
//          button and latches stall / illegal-command faults.
// Rev    : 1.0
// ============================================================================
module garage_door_position_monitor
    import garage_door_pkg::*;
#(
    parameter int POS_W        = 10,
    parameter int TRAVEL_TICKS = 600,
    parameter int STALL_CYCLES = 1000,
    parameter int DEB_CYCLES   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Up_Motor,
    input  logic             Down_Motor,
    input  logic             Enc_Pulse,
    input  logic             Remote_Btn,
    output logic             Active,
    output logic             UP_Max,
    output logic             DN_Max,
    output logic [POS_W-1:0] Position,
    output logic             Stall_Fault
);

    localparam int               STALL_W    = cnt_width(STALL_CYCLES);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);
    localparam logic [POS_W-1:0] TRAVEL_C   = POS_W'(TRAVEL_TICKS);

    logic enc_sync;
    logic btn_level;

    sync_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .BYPASS     (1'b0)
    ) u_btn (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .raw_i   (Remote_Btn),
        .level_o (btn_level)
    );

    sync_debounce #(
        .DEB_CYCLES (2),
        .BYPASS     (1'b1)
    ) u_enc (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .raw_i   (Enc_Pulse),
        .level_o (enc_sync)
    );

    logic             enc_prev_q;
    logic             tick;
    logic             dir_up;
    logic             dir_dn;
    logic             both_on;
    logic             both_off;
    logic [POS_W-1:0] pos_d;
    logic [POS_W-1:0] pos_q;
    logic             up_max_q;
    logic             dn_max_q;

    assign tick     = enc_sync & ~enc_prev_q;
    assign dir_up   = Up_Motor & ~Down_Motor;
    assign dir_dn   = Down_Motor & ~Up_Motor;
    assign both_on  = Up_Motor & Down_Motor;
    assign both_off = ~Up_Motor & ~Down_Motor;

    always_comb begin
        pos_d = pos_q;
        if (tick) begin
            if (dir_up && (pos_q != TRAVEL_C)) begin
                pos_d = pos_q + POS_W'(1);
            end else if (dir_dn && (pos_q != '0)) begin
                pos_d = pos_q - POS_W'(1);
            end
        end
    end

    // Limit flags follow pos_d so they move on the same edge as Position.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            enc_prev_q <= 1'b0;
            pos_q      <= '0;
            up_max_q   <= 1'b0;
            dn_max_q   <= 1'b1;
        end else begin
            enc_prev_q <= enc_sync;
            pos_q      <= pos_d;
            up_max_q   <= (pos_d == TRAVEL_C);
            dn_max_q   <= (pos_d == '0);
        end
    end

    mon_state_e         mon_q;
    logic [STALL_W-1:0] stall_cnt_q;
    logic               fault_q;
    logic               active_q;
    logic               last_up_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mon_q       <= MON_IDLE;
            stall_cnt_q <= '0;
            fault_q     <= 1'b0;
            active_q    <= 1'b0;
            last_up_q   <= 1'b0;
        end else begin
            active_q  <= btn_level & ~fault_q;
            last_up_q <= Up_Motor;
            case (mon_q)
                MON_IDLE: begin
                    stall_cnt_q <= '0;
                    if (both_on) begin
                        mon_q   <= MON_FAULT;
                        fault_q <= 1'b1;
                    end else if (!both_off) begin
                        mon_q <= MON_RUN;
                    end
                end
                MON_RUN: begin
                    // A tick on the limit cycle takes priority over the stall.
                    if (both_on) begin
                        mon_q   <= MON_FAULT;
                        fault_q <= 1'b1;
                    end else if (both_off) begin
                        mon_q       <= MON_IDLE;
                        stall_cnt_q <= '0;
                    end else if (tick || (Up_Motor != last_up_q)) begin
                        stall_cnt_q <= '0;
                    end else if (stall_cnt_q == STALL_LAST) begin
                        mon_q   <= MON_FAULT;
                        fault_q <= 1'b1;
                    end else begin
                        stall_cnt_q <= stall_cnt_q + STALL_W'(1);
                    end
                end
                MON_FAULT: begin
                    if (both_off && !btn_level) begin
                        mon_q       <= MON_IDLE;
                        fault_q     <= 1'b0;
                        stall_cnt_q <= '0;
                    end
                end
                default: begin
                    mon_q       <= MON_IDLE;
                    stall_cnt_q <= '0;
                end
            endcase
        end
    end

    assign Position    = pos_q;
    assign UP_Max      = up_max_q;
    assign DN_Max      = dn_max_q;
    assign Active      = active_q;
    assign Stall_Fault = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_garage_door_position_monitor.sv
`default_nettype none
// ============================================================================
// Module : tb_garage_door_position_monitor
// Brief  : Directed plus randomized bench against a cycle-level door model.
// Rev    : 1.0
// ============================================================================
module tb_garage_door_position_monitor;

    localparam int POS_W  = 10;
    localparam int TRAVEL = 8;
    localparam int STALL  = 20;
    localparam int DEB    = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             Up_Motor = 1'b0;
    logic             Down_Motor = 1'b0;
    logic             Enc_Pulse = 1'b0;
    logic             Remote_Btn = 1'b0;
    logic             Active;
    logic             UP_Max;
    logic             DN_Max;
    logic [POS_W-1:0] Position;
    logic             Stall_Fault;

    garage_door_position_monitor #(
        .POS_W        (POS_W),
        .TRAVEL_TICKS (TRAVEL),
        .STALL_CYCLES (STALL),
        .DEB_CYCLES   (DEB)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Up_Motor    (Up_Motor),
        .Down_Motor  (Down_Motor),
        .Enc_Pulse   (Enc_Pulse),
        .Remote_Btn  (Remote_Btn),
        .Active      (Active),
        .UP_Max      (UP_Max),
        .DN_Max      (DN_Max),
        .Position    (Position),
        .Stall_Fault (Stall_Fault)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model: raw input history per edge, door position, button level,
    // a run/idle/faulted mode and the number of quiet cycles while running.
    int m_pos, m_deb, m_mode, m_quiet;
    bit m_stable, m_act, m_fault, m_lastup;
    bit enc_h [3];
    bit btn_h [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_deb = 0; m_mode = 0; m_quiet = 0;
        m_stable = 0; m_act = 0; m_fault = 0; m_lastup = 0;
        enc_h = '{0, 0, 0};
        btn_h = '{0, 0};
    endtask

    task automatic model_step();
        bit tick, bsync, old_stable, old_fault, up, dn;
        up = Up_Motor; dn = Down_Motor;
        tick = enc_h[1] && !enc_h[2];
        bsync = btn_h[1];
        old_stable = m_stable;
        old_fault = m_fault;
        if (tick && up && !dn) m_pos = (m_pos < TRAVEL) ? m_pos + 1 : TRAVEL;
        if (tick && dn && !up) m_pos = (m_pos > 0) ? m_pos - 1 : 0;
        if (bsync != m_stable) begin
            m_deb++;
            if (m_deb == DEB) begin m_stable = bsync; m_deb = 0; end
        end else m_deb = 0;
        m_act = old_stable && !old_fault;
        case (m_mode)
            0: begin
                m_quiet = 0;
                if (up && dn) begin m_mode = 2; m_fault = 1; end
                else if (up || dn) m_mode = 1;
            end
            1: begin
                if (up && dn) begin m_mode = 2; m_fault = 1; end
                else if (!up && !dn) begin m_mode = 0; m_quiet = 0; end
                else if (tick || up != m_lastup) m_quiet = 0;
                else if (m_quiet == STALL - 1) begin m_mode = 2; m_fault = 1; end
                else m_quiet++;
            end
            default: if (!up && !dn && !old_stable) begin m_mode = 0; m_fault = 0; m_quiet = 0; end
        endcase
        m_lastup = up;
        enc_h[2] = enc_h[1]; enc_h[1] = enc_h[0]; enc_h[0] = Enc_Pulse;
        btn_h[1] = btn_h[0]; btn_h[0] = Remote_Btn;
    endtask

    task automatic check_all();
        chk("position", 32'(Position), 32'(m_pos));
        chk("up_max", 32'(UP_Max), 32'(m_pos == TRAVEL));
        chk("dn_max", 32'(DN_Max), 32'(m_pos == 0));
        chk("active", 32'(Active), 32'(m_act));
        chk("stall_fault", 32'(Stall_Fault), 32'(m_fault));
    endtask

    task automatic cyc();
        @(posedge CLK);
        if (RST) model_step();
        @(negedge CLK);
        check_all();
    endtask

    task automatic pulse();
        Enc_Pulse = 1'b1; cyc(); cyc();
        Enc_Pulse = 1'b0; cyc(); cyc(); cyc();
    endtask

    initial begin
        int n;
        model_reset();
        // 1: reset then idle
        #12 RST = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 10; i++) cyc();
        chk("t1_pos", 32'(Position), 32'd0);
        chk("t1_dn", 32'(DN_Max), 32'd1);
        chk("t1_up", 32'(UP_Max), 32'd0);
        chk("t1_act", 32'(Active), 32'd0);
        chk("t1_flt", 32'(Stall_Fault), 32'd0);

        // 2: glitch rejected, held button accepted after 7 edges
        Remote_Btn = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        Remote_Btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("t2_glitch_act", 32'(Active), 32'd0);
        end
        Remote_Btn = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (Active === 1'b1 && n == 0) n = i;
        end
        chk("t2_active_latency", 32'(n), 32'd7);

        // 3: open with saturation at TRAVEL
        Up_Motor = 1'b1;
        cyc();
        for (int k = 0; k < 10; k++) begin
            pulse();
            chk("t3_pos", 32'(Position), 32'((k + 1 < TRAVEL) ? k + 1 : TRAVEL));
            if (k == 0) chk("t3_dn_clear", 32'(DN_Max), 32'd0);
        end
        chk("t3_upmax", 32'(UP_Max), 32'd1);
        Up_Motor = 1'b0;
        for (int i = 0; i < 5; i++) cyc();

        // 4: stall with motor on and no ticks
        Up_Motor = 1'b1;
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            cyc();
            if (Stall_Fault === 1'b1) n = i;
        end
        chk("t4_stall_edges", 32'(n), 32'd21);
        chk("t4_act_before", 32'(Active), 32'd1);
        cyc();
        chk("t4_act_forced", 32'(Active), 32'd0);
        Up_Motor = 1'b0;
        Remote_Btn = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        chk("t4_fault_clear", 32'(Stall_Fault), 32'd0);

        // 5: both motors on with a pulse
        Up_Motor = 1'b1; Down_Motor = 1'b1; Enc_Pulse = 1'b1;
        cyc();
        chk("t5_fault", 32'(Stall_Fault), 32'd1);
        cyc(); cyc();
        Enc_Pulse = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("t5_pos", 32'(Position), 32'(TRAVEL));
        Up_Motor = 1'b0; Down_Motor = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("t5_fault_clear", 32'(Stall_Fault), 32'd0);

        // 6: asynchronous reset mid-travel
        Down_Motor = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) pulse();
        chk("t6_pos5", 32'(Position), 32'd5);
        Enc_Pulse = 1'b1;
        cyc();
        #2 RST = 1'b0;
        model_reset();
        #1;
        chk("t6_async_pos", 32'(Position), 32'd0);
        chk("t6_async_dn", 32'(DN_Max), 32'd1);
        for (int i = 0; i < 3; i++) cyc();
        Down_Motor = 1'b0; Enc_Pulse = 1'b0;
        RST = 1'b1;
        for (int k = 0; k < 3; k++) pulse();
        chk("t6_pos_after", 32'(Position), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if (i % 8 == 0) begin
                n = int'($urandom_range(0, 9));
                Up_Motor   = (n >= 3 && n < 6) || n == 9;
                Down_Motor = (n >= 6);
            end
            if ($urandom_range(0, 9) < 3) Enc_Pulse = ~Enc_Pulse;
            if ($urandom_range(0, 9) == 0) Remote_Btn = ~Remote_Btn;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
